// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode, branch-condition and FSM-state definitions plus the datapath control word.
// Combinational constants only; no latency or flow control of its own.
package cpu_ctrl_pkg;

  localparam logic [2:0] OP_ALU     = 3'b000;
  localparam logic [2:0] OP_LOAD    = 3'b001;
  localparam logic [2:0] OP_STORE   = 3'b010;
  localparam logic [2:0] OP_HALT    = 3'b011;
  localparam logic [2:0] OP_IMM     = 3'b100;
  localparam logic [2:0] OP_ILLEGAL = 3'b101;
  localparam logic [2:0] OP_BRANCH  = 3'b110;
  localparam logic [2:0] OP_JUMP    = 3'b111;

  localparam logic [3:0] FS_BR_ZERO = 4'b0000;
  localparam logic [3:0] FS_BR_NEG  = 4'b0001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_UPDATE,
    ST_HALT
  } state_e;

  typedef struct packed {
    logic       mb;
    logic       md;
    logic       rw;
    logic       mw;
    logic       pl;
    logic       jb;
    logic       bc;
    logic [3:0] fs;
    logic [2:0] dr;
    logic [2:0] sa;
    logic [2:0] sb;
  } ctrl_word_t;

  localparam ctrl_word_t CW_NOP = '0;

endpackage

// File: rtl/cpu_control_unit_if.sv
// Instruction-memory fetch port: request/address out, ack/data back.
// A request is held with a stable address until the memory acks; an ack completes it.
interface cpu_control_unit_if #(
  parameter int PC_W = 8
) ();

  logic            InstrReq;
  logic [PC_W-1:0] InstrAddr;
  logic            InstrAck;
  logic [15:0]     InstrData;

  modport master (
    output InstrReq,
    output InstrAddr,
    input  InstrAck,
    input  InstrData
  );

  modport slave (
    input  InstrReq,
    input  InstrAddr,
    output InstrAck,
    output InstrData
  );

endinterface

// File: rtl/cpu_instr_decoder.sv
// Instruction register to control word plus illegal/halt flags.
// Purely combinational, zero latency, no flow control.
module cpu_instr_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [15:0] ir_i,
  output ctrl_word_t  cw_o,
  output logic        illegal_o,
  output logic        halt_o
);

  always_comb begin
    cw_o      = CW_NOP;
    cw_o.fs   = ir_i[12:9];
    cw_o.dr   = ir_i[8:6];
    cw_o.sa   = ir_i[5:3];
    cw_o.sb   = ir_i[2:0];
    illegal_o = 1'b0;
    halt_o    = 1'b0;
    case (ir_i[15:13])
      OP_ALU:     cw_o.rw = 1'b1;
      OP_LOAD: begin
        cw_o.md = 1'b1;
        cw_o.rw = 1'b1;
      end
      OP_STORE:   cw_o.mw = 1'b1;
      OP_IMM: begin
        cw_o.mb = 1'b1;
        cw_o.rw = 1'b1;
      end
      OP_BRANCH: begin
        cw_o.pl = 1'b1;
        cw_o.bc = ir_i[9];
      end
      OP_JUMP: begin
        cw_o.pl = 1'b1;
        cw_o.jb = 1'b1;
      end
      OP_HALT:    halt_o    = 1'b1;
      OP_ILLEGAL: illegal_o = 1'b1;
      default:    ;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/execute/update sequencer producing the datapath control word.
// 4 cycles per instruction plus one per cycle the instruction memory withholds its ack.
module cpu_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Start,
  cpu_control_unit_if.master ibus,
  input  logic              Zero,
  input  logic              Negative,
  input  logic [15:0]       JumpTarget,
  output logic              MemoryBus,
  output logic              MemoryData,
  output logic              ReadWrite,
  output logic              MemoryWrite,
  output logic              ProgramReg,
  output logic              Jump,
  output logic              Branch,
  output logic [3:0]        FunctionSelect,
  output logic [2:0]        DataReg_A,
  output logic [2:0]        AddressReg_A,
  output logic [2:0]        AddressReg_B,
  output logic              ExecStrobe,
  output logic [PC_W-1:0]   ProgramCounter,
  output logic              Halted,
  output logic              IllegalOp,
  output logic [CNT_W-1:0]  InstrCount
);

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  npc_q, npc_d;
  logic [15:0]      ir_q, ir_d;
  ctrl_word_t       cw_q, cw_d;
  logic             ill_q, ill_d;
  logic             illop_q, illop_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  ctrl_word_t       dec_cw;
  logic             dec_illegal;
  logic             dec_halt;

  logic             br_taken;
  logic [PC_W-1:0]  pc_exec;
  ctrl_word_t       cw_out;
  logic             unused_jt;

  cpu_instr_decoder u_decoder (
    .ir_i      (ir_q),
    .cw_o      (dec_cw),
    .illegal_o (dec_illegal),
    .halt_o    (dec_halt)
  );

  // Only the low PC_W bits of the A operand form a jump address.
  assign unused_jt = ^JumpTarget;

  always_comb begin
    br_taken = 1'b0;
    if (cw_q.pl && !cw_q.jb) begin
      if (cw_q.fs == FS_BR_ZERO)     br_taken = Zero;
      else if (cw_q.fs == FS_BR_NEG) br_taken = Negative;
    end
    if (cw_q.jb)       pc_exec = JumpTarget[PC_W-1:0];
    else if (br_taken) pc_exec = pc_q + {{(PC_W-3){cw_q.sb[2]}}, cw_q.sb};
    else               pc_exec = pc_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    npc_d   = npc_q;
    ir_d    = ir_q;
    cw_d    = cw_q;
    ill_d   = ill_q;
    illop_d = illop_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (ibus.InstrAck) begin
          ir_d    = ibus.InstrData;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        cw_d    = dec_cw;
        ill_d   = dec_illegal;
        state_d = dec_halt ? ST_HALT : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        // Next PC is held aside so an abort before UPDATE leaves pc_q untouched.
        npc_d = pc_exec;
        if (ill_q) illop_d = 1'b1;
        state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        pc_d = npc_q;
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      npc_q   <= '0;
      ir_q    <= '0;
      cw_q    <= CW_NOP;
      ill_q   <= 1'b0;
      illop_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      ir_q    <= ir_d;
      cw_q    <= cw_d;
      ill_q   <= ill_d;
      illop_q <= illop_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cw_out = (state_q == ST_EXECUTE) ? cw_q : CW_NOP;

  assign MemoryBus      = cw_out.mb;
  assign MemoryData     = cw_out.md;
  assign ReadWrite      = cw_out.rw;
  assign MemoryWrite    = cw_out.mw;
  assign ProgramReg     = cw_out.pl;
  assign Jump           = cw_out.jb;
  assign Branch         = cw_out.bc;
  assign FunctionSelect = cw_out.fs;
  assign DataReg_A      = cw_out.dr;
  assign AddressReg_A   = cw_out.sa;
  assign AddressReg_B   = cw_out.sb;

  assign ExecStrobe     = (state_q == ST_EXECUTE);
  assign Halted         = (state_q == ST_HALT);
  assign ibus.InstrReq  = (state_q == ST_FETCH);
  assign ibus.InstrAddr = pc_q;
  assign ProgramCounter = pc_q;
  assign IllegalOp      = illop_q;
  assign InstrCount     = cnt_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit: fetch sequencing, decode, PC update, handshake, halt and reset.
module tb_cpu_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic        Zero;
  logic        Negative;
  logic [15:0] JumpTarget;
  logic        MemoryBus, MemoryData, ReadWrite, MemoryWrite, ProgramReg, Jump, Branch;
  logic [3:0]  FunctionSelect;
  logic [2:0]  DataReg_A, AddressReg_A, AddressReg_B;
  logic        ExecStrobe;
  logic [7:0]  ProgramCounter;
  logic        Halted;
  logic        IllegalOp;
  logic [15:0] InstrCount;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Results of the most recent run_instr call.
  logic [7:0]  r_addr;
  logic [20:0] r_dec, r_ex, r_upd;
  logic        r_held, r_reqdec;
  int          r_t0;
  logic        spurious_ack = 1'b0;

  cpu_control_unit_if #(.PC_W(8)) ibus ();

  cpu_control_unit #(.PC_W(8), .CNT_W(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .Start          (Start),
    .ibus           (ibus),
    .Zero           (Zero),
    .Negative       (Negative),
    .JumpTarget     (JumpTarget),
    .MemoryBus      (MemoryBus),
    .MemoryData     (MemoryData),
    .ReadWrite      (ReadWrite),
    .MemoryWrite    (MemoryWrite),
    .ProgramReg     (ProgramReg),
    .Jump           (Jump),
    .Branch         (Branch),
    .FunctionSelect (FunctionSelect),
    .DataReg_A      (DataReg_A),
    .AddressReg_A   (AddressReg_A),
    .AddressReg_B   (AddressReg_B),
    .ExecStrobe     (ExecStrobe),
    .ProgramCounter (ProgramCounter),
    .Halted         (Halted),
    .IllegalOp      (IllegalOp),
    .InstrCount     (InstrCount)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, cycles=%0d required<30000", cyc);
    $fatal(1, "watchdog");
  end

  // {MB,MD,RW,MW,PL,JB,BC, ExecStrobe, FS, DR, SA, SB}
  function automatic logic [20:0] ctrl_snap();
    return {MemoryBus, MemoryData, ReadWrite, MemoryWrite, ProgramReg, Jump, Branch,
            ExecStrobe, FunctionSelect, DataReg_A, AddressReg_A, AddressReg_B};
  endfunction

  function automatic logic [20:0] ecw(input logic [6:0] bits, input logic [15:0] ir);
    return {bits, 1'b1, ir[12:0]};
  endfunction

  // Waits (bounded) for a request, withholds ack for 'delay' cycles, then acks once.
  // Returns at the negedge of the DECODE cycle; addr is X on timeout.
  task automatic fetch(input logic [15:0] instr, input int delay,
                       output logic [7:0] addr, output logic held, output int t0);
    int n = 0;
    while (ibus.InstrReq !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    t0   = cyc;
    held = 1'b1;
    if (ibus.InstrReq !== 1'b1) begin
      addr = 'x;
      return;
    end
    addr          = ibus.InstrAddr;
    ibus.InstrAck = 1'b0;
    repeat (delay) begin
      @(negedge clk);
      if (ibus.InstrReq !== 1'b1 || ibus.InstrAddr !== addr) held = 1'b0;
    end
    ibus.InstrData = instr;
    ibus.InstrAck  = 1'b1;
    @(negedge clk);
    ibus.InstrAck  = 1'b0;
    ibus.InstrData = 16'h0000;
  endtask

  // One full instruction; leaves the bench at the negedge of the UPDATE cycle.
  task automatic run_instr(input logic [15:0] instr, input int delay);
    fetch(instr, delay, r_addr, r_held, r_t0);
    r_dec    = ctrl_snap();
    r_reqdec = ibus.InstrReq;
    if (spurious_ack) begin
      ibus.InstrAck  = 1'b1;
      ibus.InstrData = 16'h6000;
    end
    @(negedge clk);
    r_ex = ctrl_snap();
    @(negedge clk);
    r_upd = ctrl_snap();
  endtask

  task automatic start_pulse();
    @(negedge clk);
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; Start = 1'b0; Zero = 1'b0; Negative = 1'b0; JumpTarget = 16'h0;
    ibus.InstrAck = 1'b0; ibus.InstrData = 16'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (ibus.InstrReq !== 1'b0 || ExecStrobe !== 1'b0) begin failures++;
      $display("FAIL reset_req_strobe: req=%b strobe=%b required 0 0", ibus.InstrReq, ExecStrobe); end
    checks++; if (ProgramCounter !== 8'd0 || InstrCount !== 16'd0) begin failures++;
      $display("FAIL reset_pc_cnt: pc=%0d cnt=%0d required 0 0", ProgramCounter, InstrCount); end
    checks++; if (IllegalOp !== 1'b0 || Halted !== 1'b0) begin failures++;
      $display("FAIL reset_flags: illegal=%b halted=%b required 0 0", IllegalOp, Halted); end
    checks++; if (ctrl_snap() !== 21'h0) begin failures++;
      $display("FAIL reset_ctrl: got %h required 0", ctrl_snap()); end
    ibus.InstrAck = 1'b1;
    repeat (3) @(negedge clk);
    ibus.InstrAck = 1'b0;
    checks++; if (ibus.InstrReq !== 1'b0) begin failures++;
      $display("FAIL idle_no_start: req=%b required 0", ibus.InstrReq); end
    start_pulse();
    checks++; if (ibus.InstrReq !== 1'b1 || ibus.InstrAddr !== 8'd0) begin failures++;
      $display("FAIL start_fetch: req=%b addr=%0d required 1 0", ibus.InstrReq, ibus.InstrAddr); end
  endtask

  task automatic test_alu_seq();
    int prev_t0 = 0;
    for (int i = 0; i < 3; i++) begin
      run_instr(16'h0ACA, 0);
      checks++; if (r_addr !== 8'(i)) begin failures++;
        $display("FAIL alu_addr[%0d]: got %0d required %0d", i, r_addr, i); end
      checks++; if (r_dec !== 21'h0 || r_reqdec !== 1'b0) begin failures++;
        $display("FAIL alu_decode_idle[%0d]: ctrl=%h req=%b required 0 0", i, r_dec, r_reqdec); end
      checks++; if (r_ex !== ecw(7'b0010000, 16'h0ACA)) begin failures++;
        $display("FAIL alu_exec[%0d]: got %h required %h", i, r_ex, ecw(7'b0010000, 16'h0ACA)); end
      if (i > 0) begin
        checks++; if (r_t0 - prev_t0 !== 4) begin failures++;
          $display("FAIL alu_period[%0d]: got %0d required 4", i, r_t0 - prev_t0); end
      end
      prev_t0 = r_t0;
    end
    @(negedge clk);
    checks++; if (InstrCount !== 16'd3 || ProgramCounter !== 8'd3) begin failures++;
      $display("FAIL alu_count: cnt=%0d pc=%0d required 3 3", InstrCount, ProgramCounter); end
  endtask

  task automatic test_mem_ops();
    run_instr(16'h21D5, 0);
    checks++; if (r_addr !== 8'd3) begin failures++;
      $display("FAIL load_addr: got %0d required 3", r_addr); end
    checks++; if (r_ex !== ecw(7'b0110000, 16'h21D5)) begin failures++;
      $display("FAIL load_exec: got %h required %h", r_ex, ecw(7'b0110000, 16'h21D5)); end
    checks++; if (r_dec !== 21'h0 || r_upd !== 21'h0) begin failures++;
      $display("FAIL load_outside_exec: dec=%h upd=%h required 0 0", r_dec, r_upd); end
    run_instr(16'h4A53, 0);
    checks++; if (r_ex !== ecw(7'b0001000, 16'h4A53)) begin failures++;
      $display("FAIL store_exec: got %h required %h", r_ex, ecw(7'b0001000, 16'h4A53)); end
    run_instr(16'h868F, 0);
    checks++; if (r_ex !== ecw(7'b1010000, 16'h868F)) begin failures++;
      $display("FAIL imm_exec: got %h required %h", r_ex, ecw(7'b1010000, 16'h868F)); end
  endtask

  task automatic test_branch();
    JumpTarget = 16'h000A;
    run_instr(16'hE000, 0);
    checks++; if (r_addr !== 8'd6 || r_ex !== ecw(7'b0000110, 16'hE000)) begin failures++;
      $display("FAIL jump_exec: addr=%0d ctrl=%h required 6 %h", r_addr, r_ex, ecw(7'b0000110, 16'hE000)); end
    Zero = 1'b1;
    run_instr(16'hC006, 0);
    checks++; if (r_addr !== 8'd10 || r_ex !== ecw(7'b0000100, 16'hC006)) begin failures++;
      $display("FAIL brz_exec: addr=%0d ctrl=%h required 10 %h", r_addr, r_ex, ecw(7'b0000100, 16'hC006)); end
    run_instr(16'hE000, 0);
    checks++; if (r_addr !== 8'd8) begin failures++;
      $display("FAIL brz_taken: next addr %0d required 8", r_addr); end
    Zero = 1'b0;
    run_instr(16'hC006, 0);
    Negative = 1'b1;
    run_instr(16'hC203, 0);
    checks++; if (r_addr !== 8'd11) begin failures++;
      $display("FAIL brz_not_taken: next addr %0d required 11", r_addr); end
    checks++; if (r_ex !== ecw(7'b0000101, 16'hC203)) begin failures++;
      $display("FAIL brn_exec: got %h required %h", r_ex, ecw(7'b0000101, 16'hC203)); end
    Zero = 1'b1;
    run_instr(16'hC403, 0);
    checks++; if (r_addr !== 8'd14) begin failures++;
      $display("FAIL brn_taken: next addr %0d required 14", r_addr); end
    Zero = 1'b0; Negative = 1'b0;
  endtask

  task automatic test_wrap();
    JumpTarget = 16'h00FF;
    run_instr(16'hE000, 0);
    checks++; if (r_addr !== 8'd15) begin failures++;
      $display("FAIL br_other_fs: next addr %0d required 15", r_addr); end
    JumpTarget = 16'h0105;
    run_instr(16'hE000, 0);
    checks++; if (r_addr !== 8'd255) begin failures++;
      $display("FAIL jump_to_255: addr %0d required 255", r_addr); end
    JumpTarget = 16'h00FF;
    run_instr(16'hE000, 0);
    checks++; if (r_addr !== 8'd5) begin failures++;
      $display("FAIL jump_trunc: addr %0d required 5", r_addr); end
    run_instr(16'h0ACA, 0);
    Zero = 1'b1;
    run_instr(16'hC004, 0);
    checks++; if (r_addr !== 8'd0) begin failures++;
      $display("FAIL pc_wrap_up: addr %0d required 0", r_addr); end
    Zero = 1'b0;
  endtask

  task automatic test_ack_delay();
    int t_first;
    spurious_ack = 1'b1;
    run_instr(16'h0ACA, 3);
    spurious_ack = 1'b0;
    t_first = r_t0;
    checks++; if (r_addr !== 8'd252) begin failures++;
      $display("FAIL pc_wrap_down: addr %0d required 252", r_addr); end
    checks++; if (r_held !== 1'b1 || r_reqdec !== 1'b0) begin failures++;
      $display("FAIL delay_hold: held=%b req_after_ack=%b required 1 0", r_held, r_reqdec); end
    run_instr(16'h0ACA, 0);
    checks++; if (r_t0 - t_first !== 7) begin failures++;
      $display("FAIL delay_latency: got %0d cycles required 7", r_t0 - t_first); end
    checks++; if (r_addr !== 8'd253 || r_ex !== ecw(7'b0010000, 16'h0ACA)) begin failures++;
      $display("FAIL stray_ack_ignored: addr=%0d ctrl=%h required 253 %h", r_addr, r_ex, ecw(7'b0010000, 16'h0ACA)); end
  endtask

  task automatic test_illegal();
    run_instr(16'hA1FF, 0);
    checks++; if (r_addr !== 8'd254 || r_ex[20:13] !== 8'b0000_0001) begin failures++;
      $display("FAIL illegal_nop: addr=%0d ctrlbits=%b required 254 00000001", r_addr, r_ex[20:13]); end
    @(negedge clk);
    checks++; if (IllegalOp !== 1'b1 || ibus.InstrAddr !== 8'd255) begin failures++;
      $display("FAIL illegal_flag: illegal=%b addr=%0d required 1 255", IllegalOp, ibus.InstrAddr); end
  endtask

  task automatic test_halt();
    logic [7:0] a;
    logic       h;
    int         t;
    logic       bad = 1'b0;
    fetch(16'h6000, 0, a, h, t);
    @(negedge clk);
    checks++; if (Halted !== 1'b1 || ExecStrobe !== 1'b0) begin failures++;
      $display("FAIL halt_enter: halted=%b strobe=%b required 1 0", Halted, ExecStrobe); end
    Start = 1'b1; ibus.InstrAck = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      Start = 1'b0;
      if (ibus.InstrReq !== 1'b0 || Halted !== 1'b1) bad = 1'b1;
    end
    ibus.InstrAck = 1'b0;
    checks++; if (bad !== 1'b0) begin failures++;
      $display("FAIL halt_stay: left HALT or requested, bad=%b required 0", bad); end
    checks++; if (InstrCount !== 16'd20 || ProgramCounter !== 8'd255) begin failures++;
      $display("FAIL halt_count: cnt=%0d pc=%0d required 20 255", InstrCount, ProgramCounter); end
  endtask

  task automatic test_async_reset();
    logic [7:0] a;
    logic       h;
    int         t;
    #2 reset = 1'b1;
    #1;
    checks++; if (Halted !== 1'b0 || ProgramCounter !== 8'd0 || InstrCount !== 16'd0) begin failures++;
      $display("FAIL reset_from_halt: halted=%b pc=%0d cnt=%0d required 0 0 0", Halted, ProgramCounter, InstrCount); end
    @(negedge clk); reset = 1'b0;
    start_pulse();
    run_instr(16'hA000, 0);
    repeat (3) @(negedge clk);
    checks++; if (ibus.InstrReq !== 1'b1 || ibus.InstrAddr !== 8'd1 || IllegalOp !== 1'b1) begin failures++;
      $display("FAIL pre_abort_fetch: req=%b addr=%0d illegal=%b required 1 1 1", ibus.InstrReq, ibus.InstrAddr, IllegalOp); end
    #2 reset = 1'b1;
    #1;
    checks++; if (ibus.InstrReq !== 1'b0 || ProgramCounter !== 8'd0 || IllegalOp !== 1'b0) begin failures++;
      $display("FAIL abort_fetch: req=%b pc=%0d illegal=%b required 0 0 0", ibus.InstrReq, ProgramCounter, IllegalOp); end
    @(negedge clk); reset = 1'b0;
    start_pulse();
    JumpTarget = 16'h0050;
    fetch(16'hE000, 0, a, h, t);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (ExecStrobe !== 1'b0 || ctrl_snap() !== 21'h0 || ProgramCounter !== 8'd0) begin failures++;
      $display("FAIL abort_exec: strobe=%b ctrl=%h pc=%0d required 0 0 0", ExecStrobe, ctrl_snap(), ProgramCounter); end
    @(negedge clk); reset = 1'b0;
    start_pulse();
    run_instr(16'h0ACA, 0);
    @(negedge clk);
    checks++; if (r_addr !== 8'd0 || ProgramCounter !== 8'd1 || InstrCount !== 16'd1) begin failures++;
      $display("FAIL restart: addr=%0d pc=%0d cnt=%0d required 0 1 1", r_addr, ProgramCounter, InstrCount); end
  endtask

  initial begin
    test_reset();
    test_alu_seq();
    test_mem_ops();
    test_branch();
    test_wrap();
    test_ack_delay();
    test_illegal();
    test_halt();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
